// File: rtl/assert_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : assert_pkg
//  Description : Shared FSM state type and index-width helper for assert_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package assert_pkg;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_FAILED = 1'b1
    } state_t;

    // Width of a source index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : assert_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : One-hot round-robin grant over N_SRC requesters with a mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import assert_pkg::*;
#(
    parameter int N_SRC = 4
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          en,
    input  logic [N_SRC-1:0]              req,
    input  logic [N_SRC-1:0]              mask,
    output logic [N_SRC-1:0]              grant,
    output logic [id_width(N_SRC)-1:0]    grant_idx,
    output logic                          valid
);

    localparam int            IW     = id_width(N_SRC);
    localparam logic [IW-1:0] c_LAST = IW'(N_SRC - 1);

    logic [IW-1:0]    r_ptr;
    logic [N_SRC-1:0] w_elig;
    logic [IW-1:0]    w_lo_idx;
    logic [IW-1:0]    w_hi_idx;
    logic             w_lo_any;
    logic             w_hi_any;

    assign w_elig = en ? (req & ~mask) : '0;

    // Lowest eligible index at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        w_lo_idx = '0;
        w_hi_idx = '0;
        w_lo_any = 1'b0;
        w_hi_any = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo_idx = IW'(i);
                w_lo_any = 1'b1;
                if (IW'(i) >= r_ptr) begin
                    w_hi_idx = IW'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
    end

    assign valid     = w_lo_any;
    assign grant_idx = w_hi_any ? w_hi_idx : w_lo_idx;
    assign grant     = valid ? (N_SRC'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (valid) begin
            r_ptr <= (grant_idx == c_LAST) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/assert_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : assert_arbiter
//  Description : Round-robin assertion-check arbiter with pass/fail counters and
//                sticky first-failure capture. Define ASSERT_LOG_EN for sim prints.
//  Revision    : 1.0 - initial release
// ============================================================================
module assert_arbiter
    import assert_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b1
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC-1:0]              req,
    input  logic [N_SRC-1:0]              a,
    input  logic                          clr,
    output logic [N_SRC-1:0]              ack,
    output logic                          fail,
    output logic                          halt,
    output logic [id_width(N_SRC)-1:0]    fail_id,
    output logic [CNT_W-1:0]              pass_cnt,
    output logic [CNT_W-1:0]              fail_cnt
);

    localparam int IW = id_width(N_SRC);

    state_t           r_state;
    logic             w_grant_en;
    logic [N_SRC-1:0] w_gnt;
    logic [IW-1:0]    w_idx;
    logic             w_valid;
    logic             w_a_sel;

    // clr wins over any grant; a stopped arbiter leaves pending requests waiting.
    assign w_grant_en = !clr && !(STOP_ON_FAIL && (r_state == ST_FAILED));

    rr_arbiter #(
        .N_SRC     (N_SRC)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .en        (w_grant_en),
        .req       (req),
        .mask      (ack),
        .grant     (w_gnt),
        .grant_idx (w_idx),
        .valid     (w_valid)
    );

    assign w_a_sel = a[w_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            ack      <= '0;
            fail     <= 1'b0;
            halt     <= 1'b0;
            fail_id  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clr) begin
            r_state  <= ST_RUN;
            ack      <= '0;
            fail     <= 1'b0;
            halt     <= 1'b0;
            fail_id  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            ack <= w_gnt;
            if (w_valid) begin
                // Only a clean 1 passes; 0, X and Z all fall to the failure branch.
                if (w_a_sel == 1'b1) begin
                    if (pass_cnt != '1) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end
                end else begin
                    if (fail_cnt != '1) begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                    end
                    if (r_state == ST_RUN) begin
                        r_state <= ST_FAILED;
                        fail    <= 1'b1;
                        fail_id <= w_idx;
                        halt    <= STOP_ON_FAIL;
                    end
                end
            end
        end
    end

`ifdef ASSERT_LOG_EN
    always @(posedge clk) begin
        if (rst && w_valid) begin
            if ($isunknown(w_a_sel)) begin
                $display("ASSERTION UNDEFINED(x) id=%0d", w_idx);
                $display("ASSERTION FAILURE id=%0d", w_idx);
            end else if (w_a_sel) begin
                $display("ASSERTION PASS %0t", $time);
            end else begin
                $display("ASSERTION FAILURE id=%0d", w_idx);
            end
        end
    end
`else
    // Logging compiled out; datapath is identical either way.
`endif

endmodule : assert_arbiter
`default_nettype wire

// File: tb/tb_assert_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_assert_arbiter
//  Description : Self-checking bench; DUT0 stops on failure, DUT1 keeps going
//                with 2-bit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_assert_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] a   = '0;
    logic       clr = 1'b0;

    logic [3:0]  ack0, ack1;
    logic        fail0, fail1, halt0, halt1;
    logic [1:0]  id0, id1;
    logic [15:0] pc0, fc0;
    logic [1:0]  pc1, fc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assert_arbiter #(.N_SRC(4), .CNT_W(16), .STOP_ON_FAIL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .req(req), .a(a), .clr(clr),
        .ack(ack0), .fail(fail0), .halt(halt0), .fail_id(id0),
        .pass_cnt(pc0), .fail_cnt(fc0)
    );

    assert_arbiter #(.N_SRC(4), .CNT_W(2), .STOP_ON_FAIL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .req(req), .a(a), .clr(clr),
        .ack(ack1), .fail(fail1), .halt(halt1), .fail_id(id1),
        .pass_cnt(pc1), .fail_cnt(fc1)
    );

    // Reference model: index 0 mirrors DUT0's configuration, index 1 DUT1's.
    logic [3:0] m_ack  [2];
    logic       m_fail [2];
    logic       m_halt [2];
    int         m_id   [2];
    int         m_pass [2];
    int         m_fcnt [2];
    int         m_ptr  [2];
    int         win, s, cap;

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst || clr) begin
                m_ack[k] = '0; m_fail[k] = 1'b0; m_halt[k] = 1'b0;
                m_id[k] = 0; m_pass[k] = 0; m_fcnt[k] = 0; m_ptr[k] = 0;
            end else begin
                cap = (k == 0) ? 65535 : 3;
                win = -1;
                if (!(m_fail[k] && k == 0)) begin
                    for (int j = 0; j < 4; j++) begin
                        s = (m_ptr[k] + j) % 4;
                        if (win < 0 && req[s] === 1'b1 && !m_ack[k][s]) win = s;
                    end
                end
                m_ack[k] = '0;
                if (win >= 0) begin
                    m_ack[k][win] = 1'b1;
                    m_ptr[k] = (win + 1) % 4;
                    if (a[win] === 1'b1) begin
                        if (m_pass[k] < cap) m_pass[k] = m_pass[k] + 1;
                    end else begin
                        if (m_fcnt[k] < cap) m_fcnt[k] = m_fcnt[k] + 1;
                        if (!m_fail[k]) begin
                            m_fail[k] = 1'b1;
                            m_id[k] = win;
                        end
                    end
                end
                m_halt[k] = m_fail[k] && (k == 0);
            end
        end
    end

    logic [39:0] got0, exp0;
    logic [11:0] got1, exp1;

    always_comb begin
        got0 = {ack0, fail0, halt0, id0, pc0, fc0};
        got1 = {ack1, fail1, halt1, id1, pc1, fc1};
        exp0 = {m_ack[0], m_fail[0], m_halt[0], 2'(m_id[0]), 16'(m_pass[0]), 16'(m_fcnt[0])};
        exp1 = {m_ack[1], m_fail[1], m_halt[1], 2'(m_id[1]), 2'(m_pass[1]), 2'(m_fcnt[1])};
    end

    task automatic do_reset();
        req = '0; a = '0; clr = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (got0 !== 40'h0) begin errors++; $display("FAIL reset_dut0 got=%h want=0", got0); end
        checks++;
        if (got1 !== 12'h0) begin errors++; $display("FAIL reset_dut1 got=%h want=0", got1); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; a = 4'b0001;
        @(negedge clk);
        checks++;
        if (ack0 !== 4'b0001 || pc0 !== 16'd1 || fail0 !== 1'b0) begin
            errors++; $display("FAIL single_ack ack=%b pass=%0d fail=%b want 0001/1/0", ack0, pc0, fail0);
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 4'b0000 || pc0 !== 16'd1) begin
            errors++; $display("FAIL single_no_double ack=%b pass=%0d want 0000/1", ack0, pc0);
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 4'b0001 || pc0 !== 16'd2) begin
            errors++; $display("FAIL single_reack ack=%b pass=%0d want 0001/2", ack0, pc0);
        end
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        do_reset();
        req = 4'b1111; a = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            want = 4'b0001 << (i % 4);
            checks++;
            if (ack0 !== want) begin errors++; $display("FAIL rr_order cyc=%0d ack=%b want=%b", i, ack0, want); end
            checks++;
            if (got1 !== exp1) begin errors++; $display("FAIL rr_model_dut1 got=%h want=%h", got1, exp1); end
        end
        checks++;
        if (pc0 !== 16'd5) begin errors++; $display("FAIL rr_pass_cnt got=%0d want=5", pc0); end
        req = '0;
    endtask

    task automatic test_stop_on_fail();
        do_reset();
        req = 4'b0100; a = 4'b1011;
        @(negedge clk);
        checks++;
        if (fail0 !== 1'b1 || id0 !== 2'd2 || fc0 !== 16'd1 || halt0 !== 1'b1) begin
            errors++; $display("FAIL stop_capture fail=%b id=%0d fcnt=%0d halt=%b want 1/2/1/1", fail0, id0, fc0, halt0);
        end
        checks++;
        if (fail1 !== 1'b1 || halt1 !== 1'b0) begin
            errors++; $display("FAIL nostop_flags fail=%b halt=%b want 1/0", fail1, halt1);
        end
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (ack0 !== 4'b0000 || halt0 !== 1'b1) begin
                errors++; $display("FAIL stop_blocks ack=%b halt=%b want 0000/1", ack0, halt0);
            end
            checks++;
            if (got1 !== exp1) begin errors++; $display("FAIL nostop_model got=%h want=%h", got1, exp1); end
        end
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (got0 !== 40'h0) begin errors++; $display("FAIL clr_dut0 got=%h want=0", got0); end
        checks++;
        if (got1 !== 12'h0) begin errors++; $display("FAIL clr_priority_dut1 got=%h want=0", got1); end
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (ack0 !== 4'b0001 || pc0 !== 16'd1 || halt0 !== 1'b0) begin
            errors++; $display("FAIL post_clr_grant ack=%b pass=%0d halt=%b want 0001/1/0", ack0, pc0, halt0);
        end
        req = '0;
    endtask

    task automatic test_x_input();
        logic [3:0] ax;
        ax = 4'b11x1;
        do_reset();
        req = 4'b0010; a = ax;
        @(negedge clk);
        checks++;
        if (got0 !== exp0) begin errors++; $display("FAIL x_dut0 got=%h want=%h", got0, exp0); end
        checks++;
        if (got1 !== exp1) begin errors++; $display("FAIL x_dut1 got=%h want=%h", got1, exp1); end
        checks++;
        if (ack0 !== 4'b0010) begin errors++; $display("FAIL x_ack got=%b want=0010", ack0); end
        req = '0; a = '0;
    endtask

    task automatic test_saturate();
        do_reset();
        req = 4'b0001; a = 4'b0001;
        repeat (10) @(negedge clk);
        checks++;
        if (pc1 !== 2'd3 || fc1 !== 2'd0) begin
            errors++; $display("FAIL sat_cnt2 pass=%0d fcnt=%0d want 3/0", pc1, fc1);
        end
        checks++;
        if (pc0 !== 16'd5) begin errors++; $display("FAIL sat_cnt16 pass=%0d want 5", pc0); end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111; a = 4'b1111;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (got0 !== 40'h0) begin errors++; $display("FAIL midrst_dut0 got=%h want=0", got0); end
        checks++;
        if (got1 !== 12'h0) begin errors++; $display("FAIL midrst_dut1 got=%h want=0", got1); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ack0 !== 4'b0001 || ack1 !== 4'b0001) begin
            errors++; $display("FAIL midrst_first_grant ack0=%b ack1=%b want 0001", ack0, ack1);
        end
        req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (got0 !== exp0) begin errors++; $display("FAIL rand_dut0 cyc=%0d got=%h want=%h", c, got0, exp0); end
            checks++;
            if (got1 !== exp1) begin errors++; $display("FAIL rand_dut1 cyc=%0d got=%h want=%h", c, got1, exp1); end
            req = 4'($urandom);
            for (int b = 0; b < 4; b++) a[b] = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
        end
        req = '0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stop_on_fail();
        test_x_input();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_assert_arbiter
`default_nettype wire

// File: doc/assert_arbiter.md
ASSERT_ARBITER -- requirements
Module: assert_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of assertion requesters (2..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of pass/fail counters.
REQ-003 SHALL have parameter STOP_ON_FAIL, default 1, 1 = stop granting after first failure.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  N_SRC  per-source check request, held until ack.
REQ-007 SHALL have port a  input  N_SRC  per-source asserted condition, stable while req high.
REQ-008 SHALL have port clr  input  1  synchronous clear of counters, sticky flags, state.
REQ-009 SHALL have port ack  output  N_SRC  one-hot grant; check of that source completed.
REQ-010 SHALL have port fail  output  1  sticky: any failure since reset/clr.
REQ-011 SHALL have port halt  output  1  high in FAILED state when STOP_ON_FAIL=1.
REQ-012 SHALL have port fail_id  output  clog2(N_SRC)  index of first failing source.
REQ-013 SHALL have ports pass_cnt and fail_cnt  output  CNT_W each  check counts.

Function
REQ-014 SHALL grant at most one source per cycle, round-robin; pointer moves to granted index+1, wraps at N_SRC-1 -> 0.
REQ-015 SHALL sample a[i] of the winner at the edge that raises ack[i]; ack[i] high exactly one cycle (1-cycle latency req->ack when uncontended).
REQ-016 SHALL make a source acked in cycle t ineligible at the edge ending cycle t (no double count if req still high).
REQ-017 SHALL treat a sampled value of exactly 1 as pass; 0, X or Z as fail.
REQ-018 SHALL increment pass_cnt or fail_cnt by one per grant; both saturate at all-ones, no wrap.
REQ-019 SHALL implement FSM RUN/FAILED: RUN -> FAILED on first failing grant; FAILED -> RUN only via clr.
REQ-020 SHALL on first failure set fail=1 and latch fail_id; later failures update fail_cnt only.
REQ-021 SHALL, in FAILED with STOP_ON_FAIL=1, assert halt and issue no acks; pending req stay waiting.
REQ-022 SHALL, with STOP_ON_FAIL=0, keep granting in FAILED; halt stays 0.
REQ-023 SHALL, when clr and a grant coincide, give clr priority: no grant that cycle, counters 0, state RUN.

Reset
REQ-024 SHALL on rst low asynchronously force: ack=0, fail=0, halt=0, fail_id=0, pass_cnt=0, fail_cnt=0, pointer=0, state RUN.
REQ-025 SHALL drop any in-flight grant on reset mid-operation; the source must re-request.

Configuration
REQ-026 SHALL honour macro ASSERT_LOG_EN: defined -> simulation prints "ASSERTION FAILURE id=<n>" per failing grant, "ASSERTION UNDEFINED(x) id=<n>" for X/Z, "ASSERTION PASS <time>" per passing grant; undefined -> no prints, identical logic behaviour.

Structure
REQ-027 SHALL place FSM state enum and id-width helper function in shared package assert_pkg.
REQ-028 SHALL use one sub-module rr_arbiter (N_SRC one-hot round-robin grant with mask input).

Verification
REQ-029 SHALL cover: req=4'b0001, a=1 -> ack[0] next cycle, pass_cnt=1, fail=0.
REQ-030 SHALL cover: req=4'b1111 held, a=4'b1111 -> acks 0,1,2,3,0 in consecutive cycles, pass_cnt=5 after 5 cycles.
REQ-031 SHALL cover: req[2]=1, a[2]=0, STOP_ON_FAIL=1 -> fail=1, fail_id=2, fail_cnt=1, halt=1, later req[0] never acked until clr.
REQ-032 SHALL cover: a[1]=X with req[1]=1 -> counted as fail, UNDEFINED print when ASSERT_LOG_EN defined.
REQ-033 SHALL cover: CNT_W=2, 5 passing checks -> pass_cnt=3 (saturated).
REQ-034 SHALL cover: rst low mid-stream with pending req -> all outputs 0 within same cycle, first post-reset grant to source 0.
